// File: rtl/cpm_board_reset_seq.sv
// Board reset sequencer for the CPM5 EP/RP pair: POR, CPM POR and PERST release
// with link-up qualification, timed retries and sticky failure reporting.
module cpm_board_reset_seq #(
  parameter int POR_CYCLES   = 500,
  parameter int PERST_DELAY  = 100,
  parameter int LINK_TIMEOUT = 200000,
  parameter int LINK_STABLE  = 16,
  parameter int MAX_RETRIES  = 3,
  parameter int CNT_W        = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic       link_up_i,
  output logic       por_n_o,
  output logic       cpm_por_n_o,
  output logic       perst0_n_o,
  output logic       perst1_n_o,
  output logic       done,
  output logic       fail,
  output logic       link_lost,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_POR_HOLD   = 3'd1,
    ST_PERST_WAIT = 3'd2,
    ST_WAIT_LINK  = 3'd3,
    ST_LINKED     = 3'd4,
    ST_RETRY      = 3'd5,
    ST_FAIL       = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] PD_LAST   = CNT_W'(PERST_DELAY - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LINK_STABLE - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRIES);

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [CNT_W-1:0] stab_q, stab_nxt;
  logic             lu_meta_p0, lu_s;
  logic             stable_hit, timeout_hit, can_retry;
  logic             por_nxt, perst_nxt, done_nxt, fail_nxt, ll_nxt;
  logic [1:0]       retry_nxt;

  // link_up_i crosses into sys_clk here; only lu_s is used downstream
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lu_meta_p0 <= 1'b0;
      lu_s       <= 1'b0;
    end else begin
      lu_meta_p0 <= link_up_i;
      lu_s       <= lu_meta_p0;
    end
  end

  assign stable_hit  = lu_s && (stab_q == STAB_LAST);
  assign timeout_hit = (cnt_q == TO_LAST);
  assign can_retry   = ({1'b0, retry_cnt} < RETRY_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stab_q  <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      stab_q  <= stab_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    stab_nxt  = stab_q;
    case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (start) begin
          state_nxt = ST_POR_HOLD;
          cnt_nxt   = '0;
        end
      end
      ST_POR_HOLD: begin
        if (cnt_q == POR_LAST) begin
          state_nxt = ST_PERST_WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      ST_PERST_WAIT, ST_RETRY: begin
        if (cnt_q == PD_LAST) begin
          state_nxt = ST_WAIT_LINK;
          cnt_nxt   = '0;
          stab_nxt  = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LINK: begin
        cnt_nxt  = cnt_q + CNT_W'(1);
        stab_nxt = lu_s ? stab_q + CNT_W'(1) : '0;
        // a stable link on the timeout cycle still counts as linked
        if (stable_hit) begin
          state_nxt = ST_LINKED;
          cnt_nxt   = '0;
        end else if (timeout_hit) begin
          state_nxt = can_retry ? ST_RETRY : ST_FAIL;
          cnt_nxt   = '0;
        end
      end
      ST_LINKED: begin
        if (start) begin
          state_nxt = ST_POR_HOLD;
          cnt_nxt   = '0;
        end else if (!lu_s) begin
          state_nxt = ST_WAIT_LINK;
          cnt_nxt   = '0;
          stab_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        stab_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    por_nxt   = por_n_o;
    perst_nxt = perst0_n_o;
    done_nxt  = done;
    fail_nxt  = fail;
    ll_nxt    = 1'b0;
    retry_nxt = retry_cnt;
    case (state_q)
      ST_IDLE, ST_LINKED, ST_FAIL: begin
        if (start) begin
          por_nxt   = 1'b0;
          perst_nxt = 1'b0;
          done_nxt  = 1'b0;
          fail_nxt  = 1'b0;
          retry_nxt = 2'd0;
        end else if (state_q == ST_LINKED && !lu_s) begin
          done_nxt = 1'b0;
          ll_nxt   = 1'b1;
        end
      end
      ST_POR_HOLD: begin
        if (cnt_q == POR_LAST) por_nxt = 1'b1;
      end
      ST_PERST_WAIT, ST_RETRY: begin
        if (cnt_q == PD_LAST) perst_nxt = 1'b1;
      end
      ST_WAIT_LINK: begin
        if (stable_hit) begin
          done_nxt = 1'b1;
        end else if (timeout_hit) begin
          if (can_retry) begin
            perst_nxt = 1'b0;
            retry_nxt = sat_inc(retry_cnt);
          end else begin
            fail_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      por_n_o     <= 1'b0;
      cpm_por_n_o <= 1'b0;
      perst0_n_o  <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      link_lost   <= 1'b0;
      retry_cnt   <= 2'd0;
    end else begin
      por_n_o     <= por_nxt;
      cpm_por_n_o <= por_nxt;
      perst0_n_o  <= perst_nxt;
      done        <= done_nxt;
      fail        <= fail_nxt;
      link_lost   <= ll_nxt;
      retry_cnt   <= retry_nxt;
    end
  end

  assign perst1_n_o = perst0_n_o;
  assign state_o    = state_q;

endmodule
